// File: rtl/rast_pkg.sv
// Shared rasterizer definitions: datapath sizes, walker state encoding and
// the sub-sample spacing decode used by the sample-grid walker.
package rast_pkg;

  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  typedef enum logic {WAIT_STATE, TEST_STATE} walk_state_t;

  // Anything that is not one-hot falls back to whole-pixel spacing.
  function automatic logic [SIGFIG-1:0] sample_step(input logic [3:0] sub_sample,
                                                    input int radix);
    int shift;
    case (sub_sample)
      4'b0100: shift = radix - 1;
      4'b0010: shift = radix - 2;
      4'b0001: shift = radix - 3;
      default: shift = radix;
    endcase
    return {{(SIGFIG-1){1'b0}}, 1'b1} << shift;
  endfunction

endpackage

// File: rtl/grid_stepper.sv
// Combinational raster step: advances a sample position by one grid step
// inside a bounding box and flags the end of the row and of the box.
module grid_stepper #(
  parameter int W = 24
) (
  input  logic signed [W-1:0] sample      [2],
  input  logic signed [W-1:0] ll_x,
  input  logic signed [W-1:0] ur          [2],
  input  logic        [W-1:0] step,
  output logic signed [W-1:0] next_sample [2],
  output logic                row_end,
  output logic                at_last
);

  logic signed [W:0] x_inc;
  logic signed [W:0] y_inc;

  // One extra bit keeps x+step from wrapping negative near the positive limit.
  always_comb begin
    x_inc          = $signed({sample[0][W-1], sample[0]}) + $signed({1'b0, step});
    y_inc          = $signed({sample[1][W-1], sample[1]}) + $signed({1'b0, step});
    row_end        = x_inc > $signed({ur[0][W-1], ur[0]});
    at_last        = row_end && (y_inc > $signed({ur[1][W-1], ur[1]}));
    next_sample[0] = row_end ? ll_x : x_inc[W-1:0];
    next_sample[1] = row_end ? y_inc[W-1:0] : sample[1];
  end

endmodule

// File: rtl/sample_walker.sv
// Sample-grid iterator: latches a triangle and its box, then emits every
// sample position in the box in raster order, one per cycle.
module sample_walker
  import rast_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R13S    [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] color_R13U  [COLORS],
  input  logic signed [SIGFIG-1:0] box_R13S    [2][2],
  input  logic                     validTri_R13H,
  input  logic        [3:0]        subSample_RnnnnU,
  input  logic                     halt_RnnnnL,
  output logic                     halt_R13L,
  output logic signed [SIGFIG-1:0] tri_R14S    [VERTS][AXIS],
  output logic        [SIGFIG-1:0] color_R14U  [COLORS],
  output logic signed [SIGFIG-1:0] sample_R14S [2],
  output logic                     validSamp_R14H
);

  walk_state_t state, next_state;

  logic signed [SIGFIG-1:0] ll_x_q;
  logic signed [SIGFIG-1:0] ur_q        [2];
  logic signed [SIGFIG-1:0] next_sample [2];
  logic        [SIGFIG-1:0] step;
  logic                     row_end;
  logic                     at_last;
  logic                     accept;
  logic                     load;
  logic                     advance;
  logic                     finish;

  assign step = sample_step(subSample_RnnnnU, RADIX);

  grid_stepper #(.W(SIGFIG)) u_stepper (
    .sample      (sample_R14S),
    .ll_x        (ll_x_q),
    .ur          (ur_q),
    .step        (step),
    .next_sample (next_sample),
    .row_end     (row_end),
    .at_last     (at_last)
  );

  // A new triangle is taken while idle or on the last sample of the current
  // box, so consecutive boxes stream without a bubble.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    halt_R13L  = halt_RnnnnL && (state == WAIT_STATE || at_last);
    accept     = halt_R13L && validTri_R13H;
    if (halt_RnnnnL) begin
      case (state)
        WAIT_STATE: begin
          if (accept) begin
            load       = 1'b1;
            next_state = TEST_STATE;
          end
        end
        TEST_STATE: begin
          if (accept) begin
            load = 1'b1;
          end else if (at_last) begin
            finish     = 1'b1;
            next_state = WAIT_STATE;
          end else begin
            advance = 1'b1;
          end
        end
        default: next_state = WAIT_STATE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= WAIT_STATE;
      tri_R14S       <= '{default: '0};
      color_R14U     <= '{default: '0};
      sample_R14S    <= '{default: '0};
      validSamp_R14H <= 1'b0;
      ll_x_q         <= '0;
      ur_q           <= '{default: '0};
    end else begin
      state <= next_state;
      if (load) begin
        tri_R14S       <= tri_R13S;
        color_R14U     <= color_R13U;
        ll_x_q         <= box_R13S[0][0];
        ur_q           <= box_R13S[1];
        sample_R14S    <= box_R13S[0];
        validSamp_R14H <= 1'b1;
      end else if (finish) begin
        validSamp_R14H <= 1'b0;
      end else if (advance) begin
        sample_R14S[0] <= next_sample[0];
        if (row_end) begin
          sample_R14S[1] <= next_sample[1];
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_walker.sv
// Scoreboard bench for sample_walker: the driver queues every expected sample
// of each presented box; a monitor pops and compares them as they appear.
module tb_sample_walker;
  import rast_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [SIGFIG-1:0] tri_R13S    [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R13U  [COLORS];
  logic signed [SIGFIG-1:0] box_R13S    [2][2];
  logic                     validTri_R13H;
  logic        [3:0]        subSample_RnnnnU;
  logic                     halt_RnnnnL;
  logic                     halt_R13L;
  logic signed [SIGFIG-1:0] tri_R14S    [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R14U  [COLORS];
  logic signed [SIGFIG-1:0] sample_R14S [2];
  logic                     validSamp_R14H;

  always #5 clk = ~clk;

  sample_walker dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_R13S),
    .color_R13U       (color_R13U),
    .box_R13S         (box_R13S),
    .validTri_R13H    (validTri_R13H),
    .subSample_RnnnnU (subSample_RnnnnU),
    .halt_RnnnnL      (halt_RnnnnL),
    .halt_R13L        (halt_R13L),
    .tri_R14S         (tri_R14S),
    .color_R14U       (color_R14U),
    .sample_R14S      (sample_R14S),
    .validSamp_R14H   (validSamp_R14H)
  );

  typedef struct {
    longint x;
    longint y;
    int     seed;
    bit     last;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   cur_valid   = 1'b0;
  int   checks      = 0;
  int   errors      = 0;
  int   stall_cnt   = 0;
  bit   random_halt = 1'b0;
  logic drv_acc;
  logic mon_h, mon_vt, mon_r;

  function automatic longint modelStep(input logic [3:0] s);
    case (s)
      4'b0100: return 512;
      4'b0010: return 256;
      4'b0001: return 128;
      default: return 1024;
    endcase
  endfunction

  function automatic logic [SIGFIG-1:0] triVal(input int seed, input int v, input int a);
    int t;
    t = seed * 16 + v * 3 + a;
    return t[SIGFIG-1:0];
  endfunction

  function automatic logic [SIGFIG-1:0] colVal(input int seed, input int c);
    int t;
    t = seed ^ (c << 20);
    return t[SIGFIG-1:0];
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic popExpected();
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got a new sample expected none queued");
      cur_valid = 1'b0;
    end else begin
      cur       = q.pop_front();
      cur_valid = 1'b1;
    end
  endtask

  // Monitor: predicts acceptance/advance from the inputs seen at each edge.
  always begin
    logic [SIGFIG-1:0] tmp;
    @(posedge clk);
    mon_h  = halt_RnnnnL;
    mon_vt = validTri_R13H;
    mon_r  = rst;
    if (mon_r) begin
      q.delete();
      cur_valid = 1'b0;
    end else if (mon_h) begin
      if (!cur_valid || cur.last) begin
        if (mon_vt) popExpected();
        else        cur_valid = 1'b0;
      end else begin
        popExpected();
      end
    end
    #1;
    checkOutput("validSamp_R14H", longint'(validSamp_R14H), longint'(cur_valid));
    checkOutput("halt_R13L", longint'(halt_R13L),
                longint'(mon_h && (!cur_valid || cur.last)));
    if (mon_r) begin
      checkOutput("rst sample_x", longint'(sample_R14S[0]), 0);
      checkOutput("rst sample_y", longint'(sample_R14S[1]), 0);
      for (int v = 0; v < VERTS; v++)
        for (int a = 0; a < AXIS; a++) begin
          tmp = tri_R14S[v][a];
          checkOutput("rst tri", longint'(tmp), 0);
        end
      for (int c = 0; c < COLORS; c++)
        checkOutput("rst color", longint'(color_R14U[c]), 0);
    end else if (cur_valid) begin
      checkOutput("sample_x", longint'(sample_R14S[0]), cur.x);
      checkOutput("sample_y", longint'(sample_R14S[1]), cur.y);
      for (int v = 0; v < VERTS; v++)
        for (int a = 0; a < AXIS; a++) begin
          tmp = tri_R14S[v][a];
          checkOutput("tri", longint'(tmp), longint'(triVal(cur.seed, v, a)));
        end
      for (int c = 0; c < COLORS; c++)
        checkOutput("color", longint'(color_R14U[c]), longint'(colVal(cur.seed, c)));
    end
  end

  // Passes one rising edge; returns whether the presented triangle was taken.
  task automatic nextCycle(output logic acc);
    #1 acc = halt_R13L && halt_RnnnnL && validTri_R13H;
    @(negedge clk);
    if (stall_cnt > 0) begin
      halt_RnnnnL = 1'b0;
      stall_cnt--;
    end else if (random_halt) begin
      halt_RnnnnL = ($urandom_range(3) != 0);
    end else begin
      halt_RnnnnL = 1'b1;
    end
  endtask

  task automatic applyStimulus(input longint llx, input longint lly,
                               input longint urx, input longint ury, input int seed);
    longint s;
    bit     done;
    s = modelStep(subSample_RnnnnU);
    box_R13S[0][0] = llx[SIGFIG-1:0];
    box_R13S[0][1] = lly[SIGFIG-1:0];
    box_R13S[1][0] = urx[SIGFIG-1:0];
    box_R13S[1][1] = ury[SIGFIG-1:0];
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++) tri_R13S[v][a] = triVal(seed, v, a);
    for (int c = 0; c < COLORS; c++) color_R13U[c] = colVal(seed, c);
    for (longint y = lly; y <= ury; y += s)
      for (longint x = llx; x <= urx; x += s)
        q.push_back('{x: x, y: y, seed: seed, last: 1'b0});
    q[q.size()-1].last = 1'b1;
    validTri_R13H = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      nextCycle(drv_acc);
      done = drv_acc;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept seed %0d: got no accept expected accept", seed);
    end
  endtask

  task automatic waitIdle();
    bit idle;
    validTri_R13H = 1'b0;
    idle = 1'b0;
    for (int i = 0; i < 3000 && !idle; i++) begin
      if (q.size() == 0 && !cur_valid) idle = 1'b1;
      else nextCycle(drv_acc);
    end
    checkOutput("walk drained", longint'(q.size()) + longint'(cur_valid), 0);
  endtask

  initial begin
    longint s, llx, lly;
    int     k;
    logic [3:0] subs [4];
    subs[0] = 4'b1000; subs[1] = 4'b0100; subs[2] = 4'b0010; subs[3] = 4'b0001;
    rst = 1'b1;
    validTri_R13H = 1'b0;
    halt_RnnnnL = 1'b1;
    subSample_RnnnnU = 4'b1000;
    box_R13S = '{default: '0};
    tri_R13S = '{default: '0};
    color_R13U = '{default: '0};
    nextCycle(drv_acc);
    nextCycle(drv_acc);
    rst = 1'b0;

    $display("[TB] 1px 2x2 walk");
    applyStimulus(0, 0, 1024, 1024, 1);
    waitIdle();

    $display("[TB] 1/8 single row");
    subSample_RnnnnU = 4'b0001;
    applyStimulus(128, 256, 384, 256, 2);
    waitIdle();

    $display("[TB] back-to-back boxes");
    subSample_RnnnnU = 4'b0100;
    applyStimulus(0, 0, 0, 0, 3);
    applyStimulus(512, 512, 1024, 512, 4);
    waitIdle();

    $display("[TB] downstream stall");
    subSample_RnnnnU = 4'b1000;
    applyStimulus(0, 0, 1024, 1024, 5);
    validTri_R13H = 1'b0;
    stall_cnt = 3;
    nextCycle(drv_acc);
    waitIdle();

    $display("[TB] reset mid-walk");
    applyStimulus(0, 0, 1024, 1024, 6);
    validTri_R13H = 1'b0;
    nextCycle(drv_acc);
    rst = 1'b1;
    nextCycle(drv_acc);
    rst = 1'b0;
    applyStimulus(2048, 3072, 3072, 3072, 7);
    waitIdle();

    $display("[TB] near positive limit");
    applyStimulus((longint'(1) << (SIGFIG-1)) - 3072, 0,
                  (longint'(1) << (SIGFIG-1)) - 1024, 1024, 8);
    waitIdle();

    $display("[TB] non-one-hot spacing");
    subSample_RnnnnU = 4'b0110;
    applyStimulus(-1024, -1024, 1024, 0, 9);
    waitIdle();

    $display("[TB] randomized boxes");
    random_halt = 1'b1;
    for (int g = 0; g < 8; g++) begin
      subSample_RnnnnU = (g < 6) ? subs[$urandom_range(3)] : 4'($urandom_range(15));
      s = modelStep(subSample_RnnnnU);
      for (int t = 0; t < 5; t++) begin
        k   = int'($urandom_range(40)) - 20;
        llx = longint'(k) * s;
        k   = int'($urandom_range(40)) - 20;
        lly = longint'(k) * s;
        applyStimulus(llx, lly, llx + longint'($urandom_range(3)) * s,
                      lly + longint'($urandom_range(3)) * s, 100 + g * 10 + t);
        if ($urandom_range(1) == 1) begin
          validTri_R13H = 1'b0;
          repeat ($urandom_range(3)) nextCycle(drv_acc);
        end
      end
      waitIdle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_walker.md
Name: sample_walker

Overview:
- Sample-grid iterator that feeds the sample-test stage.
- Accepts one triangle, its colour and its snapped bounding box from the bbox stage (R13), then walks every sample position in the box in raster order (x fastest).
- Emits one candidate sample per cycle with triangle/colour attached (R14) and validSamp_R14H, for consumption by the edge-equation test.
- Provides active-low halt back-pressure in both directions.

Parameters:
- SIGFIG, 24, bits in colour and position.
- RADIX, 10, fraction bits in position.
- VERTS, 3, vertices per triangle.
- AXIS, 3, axes per vertex (x,y,z).
- COLORS, 3, colour channels.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- tri_R13S  in  signed SIGFIG x[VERTS][AXIS]  triangle
- color_R13U  in  SIGFIG x[COLORS]  triangle colour
- box_R13S  in  signed SIGFIG x[2][2]  [0]=lower-left (x,y), [1]=upper-right (x,y), snapped to sample grid
- validTri_R13H  in  1  triangle/box valid
- subSample_RnnnnU  in  4  one-hot sample spacing: 1000=1px, 0100=1/2, 0010=1/4, 0001=1/8
- halt_RnnnnL  in  1  downstream stall, active low
- halt_R13L  out  1  upstream stall, active low
- tri_R14S  out  signed SIGFIG x[VERTS][AXIS]  registered triangle
- color_R14U  out  SIGFIG x[COLORS]  registered colour
- sample_R14S  out  signed SIGFIG x[2]  current sample (x,y)
- validSamp_R14H  out  1  sample_R14S is a real sample

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset state: WAIT.
  - tri_R14S, color_R14U, sample_R14S, validSamp_R14H are all 0.
  - halt_R13L is combinational and reads 1 in WAIT when halt_RnnnnL=1.
- Step size: step = 1 << (RADIX - k), with k = 0,1,2,3 for 1px, 1/2, 1/4, 1/8. Default step values are 1024, 512, 256, 128.
  - subSample_RnnnnU is static while a box is being walked.
  - A non-one-hot value is illegal; implementation uses 1px.
- at_last = (sample_x + step > ur_x) AND (sample_y + step > ur_y).
  - Compare in SIGFIG+1 bits so no wrap-around occurs near the positive limit.
- accept = halt_RnnnnL AND validTri_R13H AND (state==WAIT OR at_last).
- halt_R13L = halt_RnnnnL AND (state==WAIT OR at_last).
- halt_RnnnnL = 0:
  - All registers hold and the FSM holds.
  - halt_R13L = 0.
  - Outputs are stable.
- FSM WAIT:
  - On accept, latch tri/colour/box.
  - sample_R14S <= ll, validSamp_R14H <= 1, go to TEST.
  - Latency is one cycle from accept to the first sample.
- FSM TEST (halt_RnnnnL=1), evaluated in priority order:
  1. If at_last and accept: load the new triangle as in WAIT and stay in TEST. No bubble between triangles.
  2. If at_last and no accept: validSamp_R14H <= 0, go to WAIT. sample, tri and colour hold their last values.
  3. If x + step > ur_x: x <= ll_x, y <= y + step.
  4. Otherwise: x <= x + step.
- Sample count per box: ((ur_x-ll_x)/step + 1) * ((ur_y-ll_y)/step + 1).
- Degenerate box (ll == ur): exactly one sample, at_last is true on the first cycle.
- A box with ur < ll on either axis is never presented; bbox guarantees this.
- validTri_R13H while halt_R13L=0 is ignored. Upstream must hold its data.
- rst asserted mid-walk: the next cycle is in WAIT with all outputs 0, and the partial box is discarded.

Decomposition:
- Shared package rast_pkg (extend it if it already exists) holds:
  - typedef enum logic {WAIT_STATE, TEST_STATE} walk_state_t;
  - function sample_step(subSample, RADIX) returning the step magnitude.
- One sub-module, grid_stepper (combinational): given the current sample, ll, ur and step, it produces next sample, row_end and at_last. It is kept separate so it can be unit-tested exhaustively at small SIGFIG.
- sample_walker holds the FSM, the input latches and the output registers.

Test Plan:
1. 1px, ll=(0,0), ur=(1024,1024), halt=1 -> sample_R14S over 4 cycles is (0,0), (1024,0), (0,1024), (1024,1024) with valid=1, then valid=0 and state WAIT.
2. 1/8, ll=(128,256), ur=(384,256) -> samples x=128, 256, 384 at y=256. halt_R13L=1 only in the cycle x=384, then 3 samples total.
3. Back-to-back: validTri held high with box A=(0,0)-(0,0) then box B=(512,512)-(1024,512) at 1/2 -> samples (0,0), (512,512), (1024,512) on consecutive cycles with no bubble.
4. Stall: case 1 with halt_RnnnnL=0 for 3 cycles after (1024,0) -> sample_R14S holds (1024,0) with valid=1 and halt_R13L=0, then the walk resumes at (0,1024).
5. Reset mid-walk: rst=1 while at (1024,0) -> next cycle all outputs 0, valid=0, halt_R13L=1. The new triangle afterwards starts at its own ll.
6. Near overflow: ur_x=2^(SIGFIG-1)-1024, 1px -> the last x in the row is ur_x, the walk moves to the next row with no wrap, and the sample count is correct.
